// File: rtl/behave_multiplier_nbit_if.sv
// Operand/product bus for the behavioural N x N multiplier.
interface behave_multiplier_nbit_if #(
    parameter int unsigned N = 4
);
    logic             in_valid;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [2*N-1:0]   P;
    logic             out_valid;

    // Producer of operands, consumer of products
    modport master (
        output in_valid,
        output A,
        output B,
        input  P,
        input  out_valid
    );

    // The multiplier itself
    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output P,
        output out_valid
    );
endinterface

// File: rtl/behave_multiplier_nbit.sv
// Unsigned N x N -> 2N multiplier: behavioural '*' between an operand
// register stage and a product register stage, with a valid flag.
module behave_multiplier_nbit #(
    parameter int unsigned N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    behave_multiplier_nbit_if.slave  bus
);
    localparam int unsigned OW = N;
    localparam int unsigned PW = 2 * N;

    logic [OW-1:0] a_q, a_d;
    logic [OW-1:0] b_q, b_d;
    logic          v1_q, v1_d;
    logic [PW-1:0] p_q, p_d;
    logic          ov_q, ov_d;
    logic [PW-1:0] prod_c;

    // Full-width product; operands zero-extended so no truncation occurs
    assign prod_c = PW'(a_q) * PW'(b_q);

    // Next-state: capture on in_valid, hold operands and product when idle
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        p_d  = p_q;
        v1_d = bus.in_valid;
        ov_d = v1_q;
        if (bus.in_valid) begin
            a_d = bus.A;
            b_d = bus.B;
        end
        if (v1_q) begin
            p_d = prod_c;
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            p_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            v1_q <= v1_d;
            p_q  <= p_d;
            ov_q <= ov_d;
        end
    end

    assign bus.P         = p_q;
    assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_behave_multiplier_nbit.sv
// Scoreboard bench for behave_multiplier_nbit at N=4 and N=8.
module tb_behave_multiplier_nbit;
    logic clk;
    logic rst;

    behave_multiplier_nbit_if #(.N(4)) bus4 ();
    behave_multiplier_nbit_if #(.N(8)) bus8 ();

    behave_multiplier_nbit #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    behave_multiplier_nbit #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_checks = 0;
    int n_pass   = 0;
    int seen4    = 0;
    int seen8    = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Compare every presented product against the scoreboard head
    always @(negedge clk) begin
        if (bus4.out_valid === 1'b1) begin
            seen4++;
            if (q4.size() == 0) check("spurious_valid4", 64'd1, 64'd0);
            else                check("p4", 64'(bus4.P), 64'(q4.pop_front()));
        end
        if (bus8.out_valid === 1'b1) begin
            seen8++;
            if (q8.size() == 0) check("spurious_valid8", 64'd1, 64'd0);
            else                check("p8", 64'(bus8.P), 64'(q8.pop_front()));
        end
    end

    task automatic drive4(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk); #1;
        bus4.in_valid = 1'b1;
        bus4.A        = a;
        bus4.B        = b;
        q4.push_back(8'(int'(a) * int'(b)));
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus8.in_valid = 1'b1;
        bus8.A        = a;
        bus8.B        = b;
        q8.push_back(16'(int'(a) * int'(b)));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            bus8.in_valid = 1'b0;
        end
    endtask

    // One isolated pair with explicit 2-cycle latency checks
    task automatic pair4(input logic [3:0] a, input logic [3:0] b);
        drive4(a, b);
        idle(1);
        @(negedge clk);
        check("lat1_ov", 64'(bus4.out_valid), 64'd0);
        idle(1);
        @(negedge clk);
        check("lat2_ov", 64'(bus4.out_valid), 64'd1);
        idle(1);
    endtask

    initial begin
        int base;
        logic [3:0] sa [5];
        logic [3:0] sb [5];
        sa = '{4'd3, 4'd15, 4'd10, 4'd0, 4'd9};
        sb = '{4'd5, 4'd15, 4'd3, 4'd15, 4'd9};

        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_p4",  64'(bus4.P), 64'd0);
        check("rst_ov4", 64'(bus4.out_valid), 64'd0);
        check("rst_p8",  64'(bus8.P), 64'd0);
        check("rst_ov8", 64'(bus8.out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic and boundary pairs
        pair4(4'd3, 4'd5);
        pair4(4'd10, 4'd3);
        pair4(4'd9, 4'd9);
        pair4(4'd15, 4'd15);
        pair4(4'd0, 4'd15);
        pair4(4'd1, 4'd13);

        // Idle hold after 6x7
        pair4(4'd6, 4'd7);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            @(negedge clk);
            check("hold_p", 64'(bus4.P), 64'd42);
            check("hold_ov", 64'(bus4.out_valid), 64'd0);
        end

        // Streaming: five back-to-back pairs
        idle(2);
        base = seen4;
        for (int i = 0; i < 5; i++) drive4(sa[i], sb[i]);
        @(negedge clk);
        check("stream_ov_c3", 64'(bus4.out_valid), 64'd1);
        idle(1); @(negedge clk);
        check("stream_ov_c4", 64'(bus4.out_valid), 64'd1);
        idle(1); @(negedge clk);
        check("stream_ov_c5", 64'(bus4.out_valid), 64'd1);
        idle(1); @(negedge clk);
        check("stream_ov_end", 64'(bus4.out_valid), 64'd0);
        check("stream_count", 64'(seen4 - base), 64'd5);

        // Reset with products in flight and in_valid held high during reset
        idle(3);
        base = seen4;
        drive4(4'd3, 4'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        bus4.in_valid = 1'b1;
        bus4.A = 4'd15;
        bus4.B = 4'd15;
        q4.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_p", 64'(bus4.P), 64'd0);
        check("midrst_ov", 64'(bus4.out_valid), 64'd0);
        idle(5);
        check("midrst_no_out", 64'(seen4 - base), 64'd0);
        pair4(4'd2, 4'd7);

        // Exhaustive N=4 sweep, back to back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                drive4(4'(a), 4'(b));
        idle(4);
        check("drain4", 64'(q4.size()), 64'd0);

        // N=8 corners then random pairs
        base = seen8;
        drive8(8'd255, 8'd255);
        drive8(8'd0, 8'd200);
        drive8(8'd1, 8'd77);
        drive8(8'd255, 8'd1);
        for (int i = 0; i < 996; i++)
            drive8(8'($urandom_range(255)), 8'($urandom_range(255)));
        idle(4);
        check("drain8", 64'(q8.size()), 64'd0);
        check("count8", 64'(seen8 - base), 64'd1000);
        check("max8_held", 64'(bus8.P) <= 64'd65025 ? 64'd1 : 64'd0, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #500000;
        check("watchdog", 64'd0, 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
